register_file: RTL
==================

// Module: register_file
// PURPOSE
//   Read side of the CPU register storage: 2^ADDR_WIDTH general-purpose registers
//     with one write port and two independent registered read ports (A, B).
//   Feeds the ALU operand latches in decode/execute.
//   Write-to-read bypass returns same-cycle writeback data without a stall.
//   R0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  16  bits per register / data bus width
//   ADDR_WIDTH  4   register address width; depth = 2**ADDR_WIDTH
// PORTS
//   clk           in   1           system clock, all state updates on rising edge
//   rst_n         in   1           synchronous reset, active-low
//   write_enable  in   1           write data_in to write_addr this edge
//   write_addr    in   ADDR_WIDTH  destination register
//   data_in       in   DATA_WIDTH  write data
//   read_en_a     in   1           capture port A read this edge
//   read_addr_a   in   ADDR_WIDTH  port A source register
//   read_data_a   out  DATA_WIDTH  port A registered read data
//   read_valid_a  out  1           port A data updated by the previous edge
//   read_en_b / read_addr_b / read_data_b / read_valid_b   port B, identical to A
// BEHAVIOUR
//   Reset (rst_n==0 at an edge):
//     - all registers <= 0; read_data_a/b <= 0; read_valid_a/b <= 0
//     - reset dominates any same-cycle write or read; no partial update survives
//   Write: at an edge with write_enable==1 and write_addr!=0: mem[write_addr] <= data_in.
//     - write_addr==0 is silently dropped.
//     - write_enable==0: memory is unchanged regardless of data_in.
//   Read latency is 1 cycle. At an edge with read_en_x==1:
//     - read_addr_x==0                               -> read_data_x <= 0
//     - write_enable && write_addr==read_addr_x!=0   -> read_data_x <= data_in (bypass)
//     - otherwise                                    -> read_data_x <= mem[read_addr_x]
//     - read_valid_x <= 1
//   Read hold: at an edge with read_en_x==0, read_data_x holds its last value and
//     read_valid_x <= 0.
//   Port independence: A and B may read the same or different addresses in the same
//     cycle, both with and without a concurrent write; each port resolves the bypass
//     independently.
//   No combinational path from any input to any output.
//   Width rules: addresses are used unsigned and every address is in range.
//     - no truncation; data_in is stored bit-exact.
// STRUCTURE
//   Shared package/header: DATA_WIDTH / ADDR_WIDTH defaults and the REG_ZERO = 0
//     address constant, shared with decode.
//   Storage: generate-loop of the existing register(#DATA_WIDTH) module for entries
//     1..2**ADDR_WIDTH-1.
//     - each entry's write_enable = write_enable && (write_addr == i)
//     - entry 0 is a constant 0, not instantiated
//     - the per-entry register must honour rst_n (add a synchronous active-low rst_n
//       port to register).
//   Top level: write decoder, two read mux + bypass compare, output flops.
// TESTING
//   1. Reset clears state.
//      - Stimulus: hold rst_n=0 2 cycles with write_enable=1, data_in=16'hFFFF, then
//        release and read every addr on A and B.
//      - Required: all reads 16'h0000; read_valid 0 during reset, 1 one cycle after
//        read_en.
//   2. Write-enable gating.
//      - Stimulus: write_enable=0, addr 3, data 16'h1234; then read 3.
//        Required: 16'h0000.
//      - Stimulus: write_enable=1, same write; then read 3.
//        Required: 16'h1234 exactly one cycle after read_en.
//   3. R0 immutability: write 16'hBEEF to addr 0 -> A and B reading addr 0 both return 16'h0000.
//   4. Bypass.
//      - Stimulus: same edge write_enable=1, addr 5, data 16'hA5A5; A reads 5, B reads 6
//        (which holds 16'h0006).
//      - Required: A = 16'hA5A5 (not the old value), B = 16'h0006.
//   5. Read hold.
//      - Stimulus: read A addr 3 (16'h1234); then read_en_a=0 while addr 3 is
//        rewritten to 16'h4321.
//      - Required: read_data_a stays 16'h1234 and read_valid_a drops to 0.
//      - Next read: 16'h4321.
//   6. Reset mid-operation.
//      - Stimulus: rst_n=0 on the same edge as a write of 16'h7777 to addr 7 and a
//        read of addr 7.
//      - Required: addr 7 = 0 afterwards, read_data_a = 0, read_valid_a = 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg : shared register-file widths and the zero-register address
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package register_file_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 4;
  localparam int unsigned REG_ZERO           = 0;

endpackage : register_file_pkg

`default_nettype wire

// File: rtl/register_file_if.sv
// ----------------------------------------------------------------------------
// register_file_if : write port plus two read ports of the CPU register file
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data_in;

  logic                  read_en_a;
  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic                  read_valid_a;

  logic                  read_en_b;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic                  read_valid_b;

  modport master (
    output write_enable, write_addr, data_in,
    output read_en_a, read_addr_a,
    input  read_data_a, read_valid_a,
    output read_en_b, read_addr_b,
    input  read_data_b, read_valid_b
  );

  modport slave (
    input  write_enable, write_addr, data_in,
    input  read_en_a, read_addr_a,
    output read_data_a, read_valid_a,
    input  read_en_b, read_addr_b,
    output read_data_b, read_valid_b
  );

endinterface : register_file_if

`default_nettype wire

// File: rtl/register_file_register.sv
// ----------------------------------------------------------------------------
// register : single storage word with load enable and synchronous active-low reset
// Revision 1.1
// ----------------------------------------------------------------------------
`default_nettype none

module register #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             write_enable_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic      [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (write_enable_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule : register

`default_nettype wire

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file : 2**ADDR_WIDTH x DATA_WIDTH registers, R0 reads zero, one write
//                 port, two registered read ports with write-to-read bypass
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input wire logic        clk,
  input wire logic        rst_n,
  register_file_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] w_mem [DEPTH];

  assign w_mem[0] = '0;

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
      logic w_we;
      assign w_we = bus.write_enable && (bus.write_addr == ADDR_WIDTH'(i));

      register #(
        .WIDTH (DATA_WIDTH)
      ) u_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_enable_i (w_we),
        .data_i         (bus.data_in),
        .data_o         (w_mem[i])
      );
    end : g_entry
  endgenerate

  logic [DATA_WIDTH-1:0] read_data_a_d, read_data_a_q;
  logic [DATA_WIDTH-1:0] read_data_b_d, read_data_b_q;
  logic                  read_valid_a_q, read_valid_b_q;

  // The bypass hands the in-flight writeback straight to the reader, since the
  // storage word only picks it up on this same edge.
  always_comb begin
    read_data_a_d = w_mem[bus.read_addr_a];
    if (bus.read_addr_a == ZERO_ADDR) begin
      read_data_a_d = '0;
    end else if (bus.write_enable && (bus.write_addr == bus.read_addr_a)) begin
      read_data_a_d = bus.data_in;
    end
  end

  always_comb begin
    read_data_b_d = w_mem[bus.read_addr_b];
    if (bus.read_addr_b == ZERO_ADDR) begin
      read_data_b_d = '0;
    end else if (bus.write_enable && (bus.write_addr == bus.read_addr_b)) begin
      read_data_b_d = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_a_q  <= '0;
      read_data_b_q  <= '0;
      read_valid_a_q <= 1'b0;
      read_valid_b_q <= 1'b0;
    end else begin
      read_valid_a_q <= bus.read_en_a;
      read_valid_b_q <= bus.read_en_b;
      if (bus.read_en_a) begin
        read_data_a_q <= read_data_a_d;
      end
      if (bus.read_en_b) begin
        read_data_b_q <= read_data_b_d;
      end
    end
  end

  assign bus.read_data_a  = read_data_a_q;
  assign bus.read_data_b  = read_data_b_q;
  assign bus.read_valid_a = read_valid_a_q;
  assign bus.read_valid_b = read_valid_b_q;

endmodule : register_file

`default_nettype wire
